serial_sum_deserializer: RTL and testbench

Receives the LSB-first bit-serial sum stream produced by the Moore serial adder and reassembles it into a parallel word for downstream logic. Counts accepted bits, holds the completed word behind a valid/ready handshake, and optionally captures the final adder carry. It is the receiving end of the serial adder's sum/carry_out outputs.

---
 rtl/serial_sum_deserializer.sv | 144 ++++++++++++++
 tb/tb_serial_sum_deserializer.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_sum_deserializer.sv
// Reassembles an LSB-first serial sum stream into a WIDTH-bit word behind a valid/ready handshake.
// Optional final-carry capture is built when OVERFLOW_DETECT_EN is defined.
module serial_sum_deserializer #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic             in_bit,
    input  logic             in_carry,
    input  logic             abort,
    output logic [WIDTH-1:0] out_data,
    output logic             out_carry,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             busy,
    output logic             dropped
);

    localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        HOLD  = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   sr_q, sr_d;
    logic [WIDTH-1:0]   data_q, data_d;
    logic               out_valid_q;
    logic               busy_q;
    logic               dropped_q, dropped_d;
    logic [WIDTH-1:0]   sr_shift;
    logic               final_c;

    assign sr_shift = {in_bit, sr_q[WIDTH-1:1]};

    // Next-state, counter, shift register and output word.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        sr_d      = sr_q;
        data_d    = data_q;
        dropped_d = 1'b0;
        final_c   = 1'b0;

        if (abort) begin
            state_d = IDLE;
            cnt_d   = '0;
            sr_d    = '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        sr_d    = sr_shift;
                        cnt_d   = CNT_W'(1);
                        state_d = SHIFT;
                    end
                end
                SHIFT: begin
                    if (in_valid) begin
                        sr_d = sr_shift;
                        if (cnt_q == CNT_LAST) begin
                            data_d  = sr_shift;
                            cnt_d   = '0;
                            final_c = 1'b1;
                            state_d = HOLD;
                        end else begin
                            cnt_d = cnt_q + CNT_W'(1);
                        end
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        if (in_valid) begin
                            // Handshake and new first bit in the same cycle: zero-bubble restart.
                            sr_d    = sr_shift;
                            cnt_d   = CNT_W'(1);
                            state_d = SHIFT;
                        end else begin
                            state_d = IDLE;
                        end
                    end else if (in_valid) begin
                        dropped_d = 1'b1;
                    end
                end
                default: begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    sr_d    = '0;
                end
            endcase
        end
    end

    // State and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            sr_q        <= '0;
            data_q      <= '0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            dropped_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            sr_q        <= sr_d;
            data_q      <= data_d;
            out_valid_q <= (state_d == HOLD);
            busy_q      <= (state_d != IDLE);
            dropped_q   <= dropped_d;
        end
    end

`ifdef OVERFLOW_DETECT_EN
    logic carry_q;

    // Carry is captured only with the final bit so it stays aligned with out_data.
    always_ff @(posedge clk) begin
        if (rst) begin
            carry_q <= 1'b0;
        end else if (final_c) begin
            carry_q <= in_carry;
        end
    end

    assign out_carry = carry_q;
`else
    logic unused_carry;
    assign unused_carry = in_carry ^ final_c;
    assign out_carry    = 1'b0;
`endif

    assign out_data  = data_q;
    assign out_valid = out_valid_q;
    assign busy      = busy_q;
    assign dropped   = dropped_q;

endmodule

// File: tb/tb_serial_sum_deserializer.sv
// Bench for serial_sum_deserializer: table-driven frames, directed corner sequences and
// randomized traffic checked against a word-level reference model (WIDTH=8, plus a WIDTH=4 case).
module tb_serial_sum_deserializer;

`ifdef OVERFLOW_DETECT_EN
    localparam bit CARRY_EN = 1'b1;
`else
    localparam bit CARRY_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       iv = 1'b0, ib = 1'b0, ic = 1'b0, ab = 1'b0, rdy = 1'b0;
    logic [7:0] out_data;
    logic       out_carry, out_valid, busy, dropped;

    logic       iv4 = 1'b0, ib4 = 1'b0, ic4 = 1'b0, ab4 = 1'b0, rdy4 = 1'b0;
    logic [3:0] out_data4;
    logic       out_carry4, out_valid4, busy4, dropped4;

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_en  = 1'b0;

    always #5 clk = ~clk;

    serial_sum_deserializer #(.WIDTH(8)) dut (
        .clk(clk), .rst(rst), .in_valid(iv), .in_bit(ib), .in_carry(ic), .abort(ab),
        .out_data(out_data), .out_carry(out_carry), .out_valid(out_valid),
        .out_ready(rdy), .busy(busy), .dropped(dropped)
    );

    serial_sum_deserializer #(.WIDTH(4)) dut4 (
        .clk(clk), .rst(rst), .in_valid(iv4), .in_bit(ib4), .in_carry(ic4), .abort(ab4),
        .out_data(out_data4), .out_carry(out_carry4), .out_valid(out_valid4),
        .out_ready(rdy4), .busy(busy4), .dropped(dropped4)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference model: bits collected into a word by position; a held word blocks new bits.
    logic [7:0] m_acc = '0, m_word = '0;
    int         m_n = 0;
    logic       m_valid = 1'b0, m_carry = 1'b0, m_drop = 1'b0;

    always @(posedge clk) begin
        if (rst) begin
            m_valid <= 1'b0; m_n <= 0; m_acc <= '0; m_word <= '0; m_carry <= 1'b0; m_drop <= 1'b0;
        end else if (ab) begin
            m_valid <= 1'b0; m_n <= 0; m_acc <= '0; m_drop <= 1'b0;
        end else begin
            m_drop <= 1'b0;
            if (m_valid) begin
                if (rdy) begin
                    m_valid <= 1'b0;
                    if (iv) begin
                        m_acc <= {7'b0, ib};
                        m_n   <= 1;
                    end
                end else if (iv) begin
                    m_drop <= 1'b1;
                end
            end else if (iv) begin
                if (m_n == 7) begin
                    m_word  <= {ib, m_acc[6:0]};
                    m_carry <= ic;
                    m_valid <= 1'b1;
                    m_n     <= 0;
                end else begin
                    m_acc[m_n] <= ib;
                    m_n        <= m_n + 1;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("model_valid",   32'(out_valid), 32'(m_valid));
            chk("model_busy",    32'(busy),      32'(m_valid || (m_n != 0)));
            chk("model_dropped", 32'(dropped),   32'(m_drop));
            chk("model_data",    32'(out_data),  32'(m_word));
            chk("model_carry",   32'(out_carry), 32'(CARRY_EN & m_carry));
        end
    end

    task automatic send_frame(input logic [7:0] w, input logic c, input int gap);
        for (int i = 0; i < 8; i++) begin
            iv = 1'b1;
            ib = w[i];
            ic = (i == 7) ? c : 1'b0;
            step();
            iv = 1'b0;
            ib = 1'b0;
            ic = 1'b0;
            if (i < 7) repeat (gap) step();
        end
    endtask

    typedef struct {
        logic [7:0] word;
        logic       carry;
        int         gap;
        int         hold;
        logic [7:0] exp_data;
        logic       exp_carry;
    } vec_t;

    vec_t vecs[5];

    initial begin
        vecs[0] = '{8'hA5, 1'b1, 0, 3, 8'hA5, CARRY_EN};
        vecs[1] = '{8'h5A, 1'b0, 2, 0, 8'h5A, 1'b0};
        vecs[2] = '{8'h00, 1'b1, 0, 1, 8'h00, CARRY_EN};
        vecs[3] = '{8'hFF, 1'b1, 1, 2, 8'hFF, CARRY_EN};
        vecs[4] = '{8'h81, 1'b0, 0, 0, 8'h81, 1'b0};

        // Reset state
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_data",  32'(out_data),  32'd0);
        chk("rst_carry", 32'(out_carry), 32'd0);
        chk("rst_busy",  32'(busy),      32'd0);
        chk("rst_drop",  32'(dropped),   32'd0);
        chk("rst_valid4", 32'(out_valid4), 32'd0);
        chk("rst_busy4",  32'(busy4),      32'd0);
        chk_en = 1'b1;

        // WIDTH=4: 11+13 -> sum 4'b1000 with carry out
        for (int i = 0; i < 4; i++) begin
            iv4 = 1'b1;
            ib4 = (i == 3);
            ic4 = (i == 3);
            if (i == 3) chk("w4_valid_early", 32'(out_valid4), 32'd0);
            step();
        end
        iv4 = 1'b0; ib4 = 1'b0; ic4 = 1'b0;
        chk("w4_valid", 32'(out_valid4), 32'd1);
        chk("w4_data",  32'(out_data4),  32'h8);
        chk("w4_carry", 32'(out_carry4), 32'(CARRY_EN));
        rdy4 = 1'b1;
        step();
        rdy4 = 1'b0;
        chk("w4_consumed", 32'(out_valid4), 32'd0);
        chk("w4_idle",     32'(busy4),      32'd0);

        // Table-driven frames with optional stalled handshake and a dropped bit
        for (int k = 0; k < 5; k++) begin
            rdy = 1'b0;
            send_frame(vecs[k].word, vecs[k].carry, vecs[k].gap);
            chk("vec_valid", 32'(out_valid), 32'd1);
            chk("vec_data",  32'(out_data),  32'(vecs[k].exp_data));
            chk("vec_carry", 32'(out_carry), 32'(vecs[k].exp_carry));
            if (vecs[k].hold > 0) begin
                iv = 1'b1;
                ib = ~vecs[k].word[0];
                step();
                iv = 1'b0;
                ib = 1'b0;
                chk("vec_dropped",   32'(dropped),  32'd1);
                chk("vec_drop_data", 32'(out_data), 32'(vecs[k].exp_data));
                for (int j = 1; j < vecs[k].hold; j++) begin
                    step();
                    chk("vec_hold_valid", 32'(out_valid), 32'd1);
                    chk("vec_hold_data",  32'(out_data),  32'(vecs[k].exp_data));
                end
            end
            rdy = 1'b1;
            step();
            rdy = 1'b0;
            chk("vec_consumed", 32'(out_valid), 32'd0);
            chk("vec_nodrop",   32'(dropped),   32'd0);
        end

        // Back-to-back 0x3C then 0xC3 with ready high: no bubble, no drop
        begin
            logic [15:0] pair;
            pair = 16'hC33C;
            rdy = 1'b1;
            for (int i = 0; i < 16; i++) begin
                iv = 1'b1;
                ib = pair[i];
                step();
                if (i == 7) begin
                    chk("b2b_valid0", 32'(out_valid), 32'd1);
                    chk("b2b_data0",  32'(out_data),  32'h3C);
                end
                if (i == 8) begin
                    chk("b2b_handoff", 32'(out_valid), 32'd0);
                    chk("b2b_nodrop",  32'(dropped),   32'd0);
                    chk("b2b_busy",    32'(busy),      32'd1);
                end
                if (i == 15) begin
                    chk("b2b_valid1", 32'(out_valid), 32'd1);
                    chk("b2b_data1",  32'(out_data),  32'hC3);
                end
            end
            iv = 1'b0;
            ib = 1'b0;
            step();
            rdy = 1'b0;
            chk("b2b_done", 32'(out_valid), 32'd0);
        end

        // Abort after 5 of 8 ones, then 0x0F must arrive clean
        for (int i = 0; i < 5; i++) begin
            iv = 1'b1; ib = 1'b1; step();
        end
        ab = 1'b1; iv = 1'b1; ib = 1'b1;
        step();
        ab = 1'b0; iv = 1'b0; ib = 1'b0;
        chk("abort_busy",  32'(busy),      32'd0);
        chk("abort_drop",  32'(dropped),   32'd0);
        chk("abort_valid", 32'(out_valid), 32'd0);
        send_frame(8'h0F, 1'b0, 0);
        chk("abort_next_data", 32'(out_data), 32'h0F);
        rdy = 1'b1; step(); rdy = 1'b0;

        // Reset mid-frame and during HOLD
        for (int i = 0; i < 3; i++) begin
            iv = 1'b1; ib = 1'b1; step();
        end
        iv = 1'b0; rst = 1'b1; step(); rst = 1'b0;
        chk("rstmid_busy", 32'(busy),     32'd0);
        chk("rstmid_data", 32'(out_data), 32'd0);
        send_frame(8'h12, 1'b1, 0);
        rst = 1'b1; step(); rst = 1'b0;
        chk("rsthold_valid", 32'(out_valid), 32'd0);
        chk("rsthold_data",  32'(out_data),  32'd0);
        chk("rsthold_carry", 32'(out_carry), 32'd0);
        send_frame(8'hFF, 1'b0, 0);
        chk("rst_after_data", 32'(out_data), 32'hFF);
        rdy = 1'b1; step(); rdy = 1'b0;

        // Randomized traffic, checked every cycle by the model
        for (int c = 0; c < 500; c++) begin
            iv  = 1'($urandom_range(0, 1));
            ib  = 1'($urandom_range(0, 1));
            ic  = 1'($urandom_range(0, 1));
            rdy = ($urandom_range(0, 3) != 0);
            ab  = ($urandom_range(0, 39) == 0);
            rst = ($urandom_range(0, 149) == 0);
            step();
        end
        iv = 1'b0; ib = 1'b0; ic = 1'b0; ab = 1'b0; rst = 1'b0; rdy = 1'b1;
        step();
        step();
        chk_en = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
